// File: rtl/arb2_pkg.sv
// Shared definitions for the two-input word arbiter: FSM encoding and default burst length.
package arb2_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StOwn0 = 2'b01,
    StOwn1 = 2'b10
  } arb_state_e;

  localparam int unsigned MaxBurstDef = 4;
  localparam int unsigned CountWidth  = 8;
  localparam int unsigned DataWidth   = 32;

endpackage

// File: rtl/mux2_32.sv
// 32-bit two-way data select; i_sel = 1 picks i_b.
module mux2_32 (
  input  logic        i_sel,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y
);

  assign o_y = i_sel ? i_b : i_a;

endmodule

// File: rtl/arb2_32.sv
// Two-requester word arbiter with bounded bursts, fair tie-breaking and a registered
// output stage that honours consumer backpressure.
module arb2_32
  import arb2_pkg::*;
#(
  parameter int unsigned MAX_BURST = MaxBurstDef
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] data0,
  output logic        ack0,
  input  logic        req1,
  input  logic [31:0] data1,
  output logic        ack1,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic        select
);

  arb_state_e            r_state, w_state_d;
  logic [CountWidth-1:0] r_count, w_count_d;
  logic                  r_last_owner, w_last_owner_d;
  logic                  r_out_valid;
  logic [DataWidth-1:0]  r_out_data;

  logic                  w_can_load;
  logic                  w_own_req;
  logic                  w_other_req;
  logic                  w_xfer;
  logic                  w_burst_end;
  logic [DataWidth-1:0]  w_mux_data;
  logic [CountWidth-1:0] w_burst_last;

  assign w_burst_last = CountWidth'(MAX_BURST - 1);

  assign select     = (r_state == StOwn1);
  assign w_can_load = !r_out_valid || out_ready;

  // Request of the current owner and of the other side; only meaningful in OWNx.
  assign w_own_req   = select ? req1 : req0;
  assign w_other_req = select ? req0 : req1;

  assign ack0   = (r_state == StOwn0) && req0 && w_can_load;
  assign ack1   = (r_state == StOwn1) && req1 && w_can_load;
  assign w_xfer = ack0 || ack1;

  assign w_burst_end = w_xfer && (r_count == w_burst_last);

  mux2_32 u_mux (
    .i_sel (select),
    .i_a   (data0),
    .i_b   (data1),
    .o_y   (w_mux_data)
  );

  always_comb begin
    w_state_d      = r_state;
    w_count_d      = r_count;
    w_last_owner_d = r_last_owner;
    unique case (r_state)
      StIdle: begin
        w_count_d = '0;
        if (req0 && req1) begin
          // r_last_owner names who was served last; the other side wins the tie.
          w_state_d = r_last_owner ? StOwn0 : StOwn1;
        end else if (req0) begin
          w_state_d = StOwn0;
        end else if (req1) begin
          w_state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (!w_own_req || w_burst_end) begin
          w_count_d      = '0;
          w_last_owner_d = select;
          if (w_other_req) begin
            w_state_d = select ? StOwn0 : StOwn1;
          end else begin
            w_state_d = StIdle;
          end
        end else if (w_xfer) begin
          w_count_d = r_count + CountWidth'(1);
        end
      end
      default: begin
        w_state_d = StIdle;
        w_count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_count      <= '0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_d;
      r_count      <= w_count_d;
      r_last_owner <= w_last_owner_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

`ifndef SYNTHESIS
  a_ack_onehot : assert property (@(posedge clk) disable iff (!rst_n) !(ack0 && ack1));
`endif

endmodule

// File: tb/tb_arb2_32.sv
// Directed bench for arb2_32: table-driven cycle vectors plus hand sequences for stalls,
// mid-burst reset and single-word bursts.
module tb_arb2_32;

  logic        clk;
  logic        rst_n;
  logic        req0, req1, ack0, ack1, out_valid, out_ready, select;
  logic [31:0] data0, data1, out_data;
  logic        req0_b, req1_b, ack0_b, ack1_b, out_valid_b, out_ready_b, select_b;
  logic [31:0] data0_b, data1_b, out_data_b;

  int n_cmp;
  int n_bad;

  arb2_32 #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .data0     (data0),
    .ack0      (ack0),
    .req1      (req1),
    .data1     (data1),
    .ack1      (ack1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .select    (select)
  );

  arb2_32 #(.MAX_BURST(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0_b),
    .data0     (data0_b),
    .ack0      (ack0_b),
    .req1      (req1_b),
    .data1     (data1_b),
    .ack1      (ack1_b),
    .out_valid (out_valid_b),
    .out_data  (out_data_b),
    .out_ready (out_ready_b),
    .select    (select_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic        r0, r1;
    logic [31:0] d0, d1;
    logic        rdy;
    logic        a0, a1, sel, ov;
    logic [31:0] od;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input logic r0, input logic r1, input logic [31:0] d0,
                     input logic [31:0] d1, input logic rdy, input logic a0, input logic a1,
                     input logic sel, input logic ov, input logic [31:0] od);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1; v.rdy = rdy;
    v.a0 = a0; v.a1 = a1; v.sel = sel; v.ov = ov; v.od = od;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_main(input string nm, input logic a0, input logic a1, input logic sel,
                          input logic ov, input logic [31:0] od);
    chk({nm, "_ack0"}, 32'(ack0), 32'(a0));
    chk({nm, "_ack1"}, 32'(ack1), 32'(a1));
    chk({nm, "_select"}, 32'(select), 32'(sel));
    chk({nm, "_out_valid"}, 32'(out_valid), 32'(ov));
    chk({nm, "_out_data"}, out_data, od);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 0; req1 = 0; data0 = '0; data1 = '0; out_ready = 1'b1;
    req0_b = 0; req1_b = 0; data0_b = '0; data1_b = '0; out_ready_b = 1'b1;
    #1;
    chk_main("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("reset_b_valid", 32'(out_valid_b), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b1;
    req0 = 0; req1 = 0; data0 = '0; data1 = '0; out_ready = 1'b1;
    req0_b = 0; req1_b = 0; data0_b = '0; data1_b = '0; out_ready_b = 1'b1;

    // Single word, then a tie that must favour requester 1 (0 was served last).
    add(1, 1, 0, 32'hDEADBEEF, 32'h0, 1, 0, 0, 0, 0, 32'h0);
    add(0, 1, 0, 32'hDEADBEEF, 32'h0, 1, 1, 0, 0, 0, 32'h0);
    add(0, 0, 0, 32'hDEADBEEF, 32'h0, 1, 0, 0, 0, 1, 32'hDEADBEEF);
    add(0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 32'hDEADBEEF);
    add(0, 1, 1, 32'h11, 32'h22, 1, 0, 0, 0, 0, 32'hDEADBEEF);
    add(0, 1, 1, 32'h11, 32'h22, 1, 0, 1, 1, 0, 32'hDEADBEEF);
    // Continuous tie after reset: four words each, no gap at handover.
    add(1, 1, 1, 32'hA0000001, 32'hB0000001, 1, 0, 0, 0, 0, 32'h0);
    add(0, 1, 1, 32'hA0000001, 32'hB0000001, 1, 1, 0, 0, 0, 32'h0);
    add(0, 1, 1, 32'hA0000002, 32'hB0000001, 1, 1, 0, 0, 1, 32'hA0000001);
    add(0, 1, 1, 32'hA0000003, 32'hB0000001, 1, 1, 0, 0, 1, 32'hA0000002);
    add(0, 1, 1, 32'hA0000004, 32'hB0000001, 1, 1, 0, 0, 1, 32'hA0000003);
    add(0, 1, 1, 32'hA0000005, 32'hB0000001, 1, 0, 1, 1, 1, 32'hA0000004);
    add(0, 1, 1, 32'hA0000005, 32'hB0000002, 1, 0, 1, 1, 1, 32'hB0000001);
    add(0, 1, 1, 32'hA0000005, 32'hB0000003, 1, 0, 1, 1, 1, 32'hB0000002);
    add(0, 1, 1, 32'hA0000005, 32'hB0000004, 1, 0, 1, 1, 1, 32'hB0000003);
    add(0, 1, 1, 32'hA0000005, 32'hB0000005, 1, 1, 0, 0, 1, 32'hB0000004);
    // Early release by requester 1, then a tie goes to requester 0.
    add(1, 0, 1, 32'h0, 32'hC0000001, 1, 0, 0, 0, 0, 32'h0);
    add(0, 0, 1, 32'h0, 32'hC0000001, 1, 0, 1, 1, 0, 32'h0);
    add(0, 0, 1, 32'h0, 32'hC0000002, 1, 0, 1, 1, 1, 32'hC0000001);
    add(0, 0, 0, 32'h0, 32'hC0000002, 1, 0, 0, 1, 1, 32'hC0000002);
    add(0, 1, 1, 32'hD0000001, 32'hC0000003, 1, 0, 0, 0, 0, 32'hC0000002);
    add(0, 1, 1, 32'hD0000001, 32'hC0000003, 1, 1, 0, 0, 0, 32'hC0000002);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      req0 = vecs[i].r0; req1 = vecs[i].r1;
      data0 = vecs[i].d0; data1 = vecs[i].d1; out_ready = vecs[i].rdy;
      #1;
      chk_main($sformatf("vec%0d", i), vecs[i].a0, vecs[i].a1, vecs[i].sel, vecs[i].ov,
               vecs[i].od);
    end

    // Backpressure while requester 1 owns the bus.
    do_reset();
    @(negedge clk); req1 = 1; data1 = 32'hE0000001; out_ready = 1; #1;
    chk_main("bp_idle", 0, 0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk_main("bp_w1", 0, 1, 1, 0, 32'h0);
    @(negedge clk); data1 = 32'hE0000002; #1;
    chk_main("bp_w2", 0, 1, 1, 1, 32'hE0000001);
    @(negedge clk); data1 = 32'hE0000003; out_ready = 0; #1;
    chk_main("bp_stall0", 0, 0, 1, 1, 32'hE0000002);
    for (int s = 1; s < 5; s++) begin
      @(negedge clk); #1;
      chk_main($sformatf("bp_stall%0d", s), 0, 0, 1, 1, 32'hE0000002);
    end
    @(negedge clk); out_ready = 1; #1;
    chk_main("bp_w3", 0, 1, 1, 1, 32'hE0000002);
    @(negedge clk); data1 = 32'hE0000004; #1;
    chk_main("bp_w4", 0, 1, 1, 1, 32'hE0000003);
    @(negedge clk); data1 = 32'hE0000005; #1;
    chk_main("bp_burst_end", 0, 0, 0, 1, 32'hE0000004);

    // Reset asserted mid-burst with a word held in the output register.
    do_reset();
    @(negedge clk); req0 = 1; data0 = 32'hF0000001; #1;
    chk_main("mr_idle", 0, 0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk_main("mr_w1", 1, 0, 0, 0, 32'h0);
    @(negedge clk); data0 = 32'hF0000002; #1;
    chk_main("mr_w2", 1, 0, 0, 1, 32'hF0000001);
    rst_n = 1'b0; #1;
    chk_main("mr_async", 0, 0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk_main("mr_held", 0, 0, 0, 0, 32'h0);
    rst_n = 1'b1; req1 = 1; #1;
    chk_main("mr_release", 0, 0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk_main("mr_tie", 1, 0, 0, 0, 32'h0);

    // MAX_BURST = 1: strict alternation every cycle.
    do_reset();
    begin
      int          n0, n1;
      logic        owner, have;
      logic [31:0] last_word;
      n0 = 1; n1 = 1; owner = 0; have = 0; last_word = '0;
      @(negedge clk);
      req0_b = 1; req1_b = 1;
      data0_b = 32'h50000000 + 32'(n0); data1_b = 32'h60000000 + 32'(n1);
      #1;
      chk("mb1_idle_ack0", 32'(ack0_b), 32'h0);
      chk("mb1_idle_ack1", 32'(ack1_b), 32'h0);
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        data0_b = 32'h50000000 + 32'(n0); data1_b = 32'h60000000 + 32'(n1);
        #1;
        chk($sformatf("mb1_%0d_ack0", i), 32'(ack0_b), 32'(!owner));
        chk($sformatf("mb1_%0d_ack1", i), 32'(ack1_b), 32'(owner));
        chk($sformatf("mb1_%0d_select", i), 32'(select_b), 32'(owner));
        chk($sformatf("mb1_%0d_valid", i), 32'(out_valid_b), 32'(have));
        chk($sformatf("mb1_%0d_data", i), out_data_b, last_word);
        last_word = owner ? data1_b : data0_b;
        if (owner) n1++;
        else n0++;
        have = 1;
        owner = !owner;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
